// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, default address, ACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  localparam logic [6:0] DEF_DEV_ADDR = 7'b1010_100;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises one open-drain bus line, accepts a new level only after FILT_LEN equal
// samples, and emits single-cycle rise/fall pulses aligned with the level change.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Bus idles high, so the filtered level starts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing REG_NUM 8-bit registers (pointer byte + data bytes), with a
// host-side read/write port and a pulse for every register committed over I2C.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
  parameter int unsigned REG_NUM  = 16,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scl_in,
  input  logic                       sda_in,
  output logic                       sda_oe,
  input  logic                       host_wr_en,
  input  logic [$clog2(REG_NUM)-1:0] host_addr,
  input  logic [7:0]                 host_wdata,
  output logic [7:0]                 host_rdata,
  output logic                       wr_evt,
  output logic [$clog2(REG_NUM)-1:0] wr_evt_addr,
  output logic [7:0]                 wr_evt_data,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(REG_NUM);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .pin   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .pin   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [REG_NUM];
  logic [7:0]    sh;
  logic [3:0]    bit_cnt;
  logic          rw;
  logic [7:0]    rx_byte;

  assign rx_byte = {sh[6:0], sda_lvl};

  // In the ACK states sda_oe doubles as the phase flag: first scl_fall drives, second releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      sh          <= '0;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_evt      <= 1'b0;
      wr_evt_addr <= '0;
      wr_evt_data <= '0;
      host_rdata  <= '0;
      for (int i = 0; i < int'(REG_NUM); i++) regs[i] <= '0;
    end else begin
      wr_evt     <= 1'b0;
      host_rdata <= regs[host_addr];
      if (host_wr_en) regs[host_addr] <= host_wdata;

      if (stop_det) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            sh      <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state <= ST_ADDR_ACK;
                rw    <= rx_byte[0];
                busy  <= 1'b1;
              end else begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end

          ST_PTR: if (scl_rise) begin
            sh      <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (32'(rx_byte) < REG_NUM) begin
                ptr   <= AW'(rx_byte);
                state <= ST_PTR_ACK;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end

          // I2C write is placed after the host write so it wins on an index collision.
          ST_WDATA: if (scl_rise) begin
            sh      <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              regs[ptr]   <= rx_byte;
              wr_evt      <= 1'b1;
              wr_evt_addr <= ptr;
              wr_evt_data <= rx_byte;
              ptr         <= ptr + AW'(1);
              state       <= ST_WDATA_ACK;
            end
          end

          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              bit_cnt <= '0;
              if (rw) begin
                sh     <= {regs[ptr][6:0], 1'b0};
                sda_oe <= ~regs[ptr][7];
                ptr    <= ptr + AW'(1);
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_PTR;
              end
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= ST_RDATA_ACK;
              end else begin
                sda_oe <= ~sh[7];
                sh     <= {sh[6:0], 1'b0};
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == NACK) state <= ST_WAIT_STOP;
            end else if (scl_fall) begin
              sh      <= {regs[ptr][6:0], 1'b0};
              sda_oe  <= ~regs[ptr][7];
              ptr     <= ptr + AW'(1);
              bit_cnt <= '0;
              state   <= ST_RDATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: an I2C master model drives SCL/SDA, and a register-file
// reference model predicts ACKs, read data, write events and host-port contents.
module tb_i2c_target;

  localparam int unsigned REG_NUM = 16;
  localparam int unsigned AW      = 4;
  localparam int          H       = 16;   // half SCL period in clk cycles

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, scl, sda_m, sda_bus;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata, host_rdata;
  logic          sda_oe, wr_evt, busy;
  logic [AW-1:0] wr_evt_addr;
  logic [7:0]    wr_evt_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(.DEV_ADDR(7'b1010_100), .REG_NUM(REG_NUM), .FILT_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .host_wr_en  (host_wr_en),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .wr_evt      (wr_evt),
    .wr_evt_addr (wr_evt_addr),
    .wr_evt_data (wr_evt_data),
    .busy        (busy)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  mregs [REG_NUM];
  int          mptr;
  logic [11:0] exp_ev[$];
  logic [11:0] got_ev[$];
  logic [7:0]  wq[$];
  logic        watch;
  int          oe_seen, busy_seen;
  logic [7:0]  d8;
  logic        a;
  int          p, n, hidx;
  logic [7:0]  hval;

  // Observe outputs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (wr_evt) got_ev.push_back({wr_evt_addr, wr_evt_data});
    if (watch && sda_oe) oe_seen++;
    if (watch && busy) busy_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // One SCL period starting and ending with SCL low; SDA changes mid-low, sampled mid-high.
  task automatic clock_bit(input logic d, input logic hook, output logic s);
    cyc(H/2); sda_m = d;
    cyc(H/2); scl = 1'b1;
    if (hook) begin
      cyc(6); host_wr_en = 1'b1;
      cyc(1); host_wr_en = 1'b0;
      check("collide_evt", 32'(wr_evt), 32'd1);
      cyc(H/2 - 7);
    end else begin
      cyc(H/2);
    end
    s = sda_bus;
    cyc(H/2); scl = 1'b0;
  endtask

  task automatic start_cond();
    if (!scl) begin
      cyc(H/2); sda_m = 1'b1;
      cyc(H/2); scl = 1'b1;
    end
    cyc(H/2); sda_m = 1'b0;
    cyc(H/2); scl = 1'b0;
  endtask

  task automatic stop_cond();
    cyc(H/2); sda_m = 1'b0;
    cyc(H/2); scl = 1'b1;
    cyc(H/2); sda_m = 1'b1;
    cyc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic hook, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], hook && (i == 0), s);
    clock_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clock_bit(~mack, 1'b0, s);
  endtask

  task automatic host_read(input int idx, output logic [7:0] d);
    host_addr = 4'(idx);
    cyc(2);
    d = host_rdata;
  endtask

  task automatic host_write(input int idx, input logic [7:0] v);
    host_addr = 4'(idx); host_wdata = v; host_wr_en = 1'b1;
    cyc(1);
    host_wr_en = 1'b0;
    mregs[idx] = v;
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_nevt"}, 32'(got_ev.size()), 32'(exp_ev.size()));
    foreach (exp_ev[k])
      if (k < got_ev.size()) check({tag, "_evt"}, 32'(got_ev[k]), 32'(exp_ev[k]));
    got_ev.delete();
    exp_ev.delete();
  endtask

  // Write transaction: address byte, pointer byte, then the bytes queued in wq.
  // hook_k selects the data byte whose commit coincides with a host write (-1: none).
  task automatic i2c_write(input logic [7:0] ab, input int ptr, input int hook_k, input string tag);
    logic ack, match, pok;
    match = (ab[7:1] == 7'h54) && !ab[0];
    start_cond();
    send_byte(ab, 1'b0, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'(match));
    check({tag, "_busy"}, 32'(busy), 32'(match));
    pok = match && (ptr < REG_NUM);
    send_byte(8'(ptr), 1'b0, ack);
    check({tag, "_ptr_ack"}, 32'(ack), 32'(pok));
    if (pok) mptr = ptr;
    foreach (wq[k]) begin
      send_byte(wq[k], k == hook_k, ack);
      check({tag, "_data_ack"}, 32'(ack), 32'(pok));
      if (k == hook_k) mregs[host_addr] = host_wdata;
      if (pok) begin
        mregs[mptr] = wq[k];
        exp_ev.push_back({4'(mptr), wq[k]});
        mptr = (mptr + 1) % REG_NUM;
      end
    end
    stop_cond();
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    compare_events(tag);
  endtask

  // Set pointer, repeated START, read nb bytes (ACK all but the last).
  task automatic i2c_read(input int ptr, input int nb, input string tag);
    logic ack;
    logic [7:0] d;
    start_cond();
    send_byte(8'hA8, 1'b0, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'd1);
    send_byte(8'(ptr), 1'b0, ack);
    check({tag, "_ptr_ack"}, 32'(ack), 32'(ptr < REG_NUM));
    if (ptr < REG_NUM) mptr = ptr;
    start_cond();
    send_byte(8'hA9, 1'b0, ack);
    check({tag, "_raddr_ack"}, 32'(ack), 32'd1);
    for (int k = 0; k < nb; k++) begin
      recv_byte(k < nb - 1, d);
      check({tag, "_rdata"}, 32'(d), 32'(mregs[mptr]));
      mptr = (mptr + 1) % REG_NUM;
    end
    cyc(4);
    check({tag, "_oe_released"}, 32'(sda_oe), 32'd0);
    stop_cond();
    compare_events(tag);
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    host_wr_en = 1'b0; host_addr = '0; host_wdata = '0;
    watch = 1'b0; oe_seen = 0; busy_seen = 0; mptr = 0;
    for (int i = 0; i < REG_NUM; i++) mregs[i] = 8'h00;

    // Reset state
    cyc(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_evt", 32'(wr_evt), 32'd0);
    check("rst_evt_addr", 32'(wr_evt_addr), 32'd0);
    check("rst_evt_data", 32'(wr_evt_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b0;
    cyc(8);
    host_read(3, d8); check("rst_reg3", 32'(d8), 32'd0);

    // Write two bytes at pointer 3
    wq.delete(); wq.push_back(8'h5A); wq.push_back(8'hC3);
    i2c_write(8'hA8, 3, -1, "wr");
    host_read(3, d8); check("wr_reg3", 32'(d8), 32'h5A);
    host_read(4, d8); check("wr_reg4", 32'(d8), 32'hC3);

    // Read them back with repeated START
    i2c_read(3, 2, "rd");

    // Wrong address: no ACK, SDA never driven, busy stays low
    watch = 1'b1;
    wq.delete(); wq.push_back(8'h12); wq.push_back(8'h34);
    i2c_write(8'hAA, 3, -1, "badaddr");
    watch = 1'b0;
    check("badaddr_oe_seen", 32'(oe_seen), 32'd0);
    check("badaddr_busy_seen", 32'(busy_seen), 32'd0);
    host_read(3, d8); check("badaddr_reg3", 32'(d8), 32'(mregs[3]));

    // Out-of-range pointer, then wrap from the last register
    wq.delete(); wq.push_back(8'hEE);
    i2c_write(8'hA8, 16, -1, "ptr_oob");
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    i2c_write(8'hA8, 15, -1, "ptr_wrap");
    host_read(15, d8); check("wrap_reg15", 32'(d8), 32'h11);
    host_read(0, d8);  check("wrap_reg0", 32'(d8), 32'h22);

    // STOP after four data bits discards the partial byte
    start_cond();
    send_byte(8'hA8, 1'b0, a); check("partial_addr_ack", 32'(a), 32'd1);
    send_byte(8'h06, 1'b0, a); check("partial_ptr_ack", 32'(a), 32'd1);
    mptr = 6;
    for (int i = 0; i < 4; i++) clock_bit(i[0], 1'b0, a);
    stop_cond();
    compare_events("partial");
    host_read(6, d8); check("partial_reg6", 32'(d8), 32'(mregs[6]));

    // Reset while the target drives a read bit
    host_write(8, 8'h3C);
    start_cond();
    send_byte(8'hA8, 1'b0, a);
    send_byte(8'h08, 1'b0, a);
    start_cond();
    send_byte(8'hA9, 1'b0, a); check("rdrst_addr_ack", 32'(a), 32'd1);
    cyc(H/2);
    check("rdrst_driving", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    cyc(1);
    check("rdrst_oe_release", 32'(sda_oe), 32'd0);
    check("rdrst_busy", 32'(busy), 32'd0);
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < REG_NUM; i++) mregs[i] = 8'h00;
    mptr = 0;
    got_ev.delete();
    stop_cond();
    host_read(8, d8); check("rdrst_reg8", 32'(d8), 32'd0);

    // Host and I2C write in the same cycle: same index (I2C wins), then different indices
    host_addr = 4'd5; host_wdata = 8'h77;
    wq.delete(); wq.push_back(8'h99);
    i2c_write(8'hA8, 5, 0, "collide_same");
    host_read(5, d8); check("collide_reg5", 32'(d8), 32'h99);
    host_addr = 4'd9; host_wdata = 8'h44;
    wq.delete(); wq.push_back(8'h55);
    i2c_write(8'hA8, 6, 0, "collide_diff");
    host_read(9, d8); check("collide_reg9", 32'(d8), 32'h44);
    host_read(6, d8); check("collide_reg6", 32'(d8), 32'h55);

    // Randomised writes, host writes and reads against the register model
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(0, 19));
      n = int'($urandom_range(1, 3));
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
      i2c_write(8'hA8, p, -1, "rnd_wr");
      hidx = int'($urandom_range(0, 15));
      hval = 8'($urandom_range(0, 255));
      host_write(hidx, hval);
      i2c_read(int'($urandom_range(0, 17)), 2, "rnd_rd");
      hidx = int'($urandom_range(0, 15));
      host_read(hidx, d8); check("rnd_host_rd", 32'(d8), 32'(mregs[hidx]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
